// File: rtl/fp_mac_pkg.sv
// Shared types and constants for the FP dot-product accumulation sequencer.
package fp_mac_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1
   } state_t;

   localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
   localparam int          LAT_DEF     = 4;

endpackage

// File: rtl/fp_mac_lat_tracker.sv
// Tracks the single in-flight adder operation: pending flag and
// return timer, flagging a missing result or one nobody asked for.
module fp_mac_lat_tracker
   import fp_mac_pkg::*;
#(
   parameter int LAT = LAT_DEF
) (
   input  logic CLK,
   input  logic RESET,
   input  logic issue,
   input  logic res_valid,
   output logic pend,
   output logic timeout,
   output logic spurious
);

   localparam int TW = $clog2(LAT + 1);

   logic [TW-1:0] tmr;

   // The result is due on the LAT-th cycle after issue; absent then means lost.
   assign timeout  = pend & ~res_valid & (tmr == TW'(LAT - 1));
   assign spurious = res_valid & ~pend;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         pend <= 1'b0;
         tmr  <= '0;
      end else if (issue) begin
         pend <= 1'b1;
         tmr  <= '0;
      end else if (pend & res_valid) begin
         pend <= 1'b0;
      end else if (timeout) begin
         pend <= 1'b0;
         tmr  <= '0;
      end else if (pend) begin
         tmr  <= tmr + 1'b1;
      end
   end

endmodule

// File: rtl/fp_mac_acc_seq.sv
// Streams LEN products through the FP adder, one in flight at a time,
// feeding each result straight back as the next accumulator operand.
module fp_mac_acc_seq
   import fp_mac_pkg::*;
#(
   parameter int LAT   = LAT_DEF,
   parameter int LEN_W = 8,
   parameter int W     = 32
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_prod,
   output logic             add_valid,
   output logic [W-1:0]     add_a,
   output logic [W-1:0]     add_b,
   input  logic             res_valid,
   input  logic [W-1:0]     res_data,
   output logic             out_valid,
   output logic [W-1:0]     out_data,
   output logic             busy,
   output logic             err
);

   state_t           state;
   logic [W-1:0]     acc;
   logic [LEN_W-1:0] cnt;
   logic             pend;
   logic             timeout;
   logic             spurious;
   logic             accept;
   logic             ret;
   logic             run;

   assign run       = (state == RUN);
   assign in_ready  = run & (cnt != '0) & (~pend | res_valid);
   assign accept    = in_valid & in_ready;
   assign ret       = run & pend & res_valid;
   assign add_valid = accept;
   assign add_a     = (pend & res_valid) ? res_data : acc;
   assign add_b     = in_prod;
   assign busy      = (state != IDLE);

   fp_mac_lat_tracker #(
      .LAT (LAT)
   ) u_trk (
      .CLK       (CLK),
      .RESET     (RESET),
      .issue     (accept),
      .res_valid (res_valid),
      .pend      (pend),
      .timeout   (timeout),
      .spurious  (spurious)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= IDLE;
         acc       <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         err       <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  err <= 1'b0;
                  if (len == '0) begin
                     out_data  <= W'(FP_POS_ZERO);
                     out_valid <= 1'b1;
                  end else begin
                     acc   <= '0;
                     cnt   <= len;
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if (accept)
                  cnt <= cnt - 1'b1;
               if (ret) begin
                  acc <= res_data;
                  if (cnt == '0) begin
                     out_data  <= res_data;
                     out_valid <= 1'b1;
                     state     <= IDLE;
                  end
               end
               // A lost result leaves acc as it was and moves on.
               if (timeout) begin
                  err <= 1'b1;
                  if (cnt == '0) begin
                     out_data  <= acc;
                     out_valid <= 1'b1;
                     state     <= IDLE;
                  end
               end
               if (spurious)
                  err <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
